// File: rtl/mem_stage_if.sv
// mem_stage_if: data-bus request/ack channel between the MEM stage and memory
// Ports: mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb driven by master (stage),
//        mem_ack/mem_rdata driven by slave (memory); rdata is valid with ack.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (bus handshake, load align/extend, MEM forwarding bundle)
// Ports: i_clk/i_rst_n (async active-low); EX side i_valid/o_ready/i_rd/i_result/i_store_data/
//        i_is_load/i_is_store/i_funct3; bus (mem_stage_if.master); writeback o_wb_valid/o_wb_rd/
//        o_wb_data; o_mem_bypass {rd,data}; o_pause stall; o_bus_err timeout pulse.
// Option MEM_MISALIGN_TRAP_EN adds o_misalign/o_misalign_addr and suppresses misaligned accesses.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mem_stage_if.master bus,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  input  logic [31:0] i_store_data,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic [36:0] o_mem_bypass,
  output logic        o_pause,
  output logic        o_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign,
  output logic [31:0] o_misalign_addr
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q, wdata_n, fmt;
  logic [3:0]    wstrb_q, wstrb_n;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          ld_q, we_q, mem_op, mis, tmo;
  logic [1:0]    sz, off;
  logic [7:0]    lb;
  logic [15:0]   lh;
  always_comb begin
    mem_op  = i_is_load | i_is_store;
    sz      = i_funct3[1:0];
    off     = i_result[1:0];
    wdata_n = sz == 2'b00 ? {4{i_store_data[7:0]}} : sz == 2'b01 ? {2{i_store_data[15:0]}} : i_store_data;
    wstrb_n = sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
`ifdef MEM_MISALIGN_TRAP_EN
    mis     = mem_op & ((sz == 2'b01 & off[0]) | (sz[1] & |off));
`else
    mis     = 1'b0;
`endif
    lb      = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lh      = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    // funct3[2] selects zero-extension; codes with size 2'b10/2'b11 all read as a full word
    fmt     = f3_q[1:0] == 2'b00 ? {{24{lb[7] & ~f3_q[2]}}, lb} :
              f3_q[1:0] == 2'b01 ? {{16{lh[15] & ~f3_q[2]}}, lh} : bus.mem_rdata;
    tmo     = TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES - 1;
  end
  assign o_pause       = state == BUS;
  assign o_ready       = ~o_pause;
  assign bus.mem_req   = state == BUS;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign o_mem_bypass  = o_wb_valid ? {o_wb_rd, o_wb_data} : 37'd0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      ld_q       <= 1'b0;
      we_q       <= 1'b0;
      o_wb_valid <= 1'b0;
      o_wb_rd    <= '0;
      o_wb_data  <= '0;
      o_bus_err  <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      o_bus_err  <= 1'b0;
      if (state == IDLE) begin
        if (i_valid && mem_op && !mis) begin
          state   <= BUS;
          cnt     <= '0;
          addr_q  <= i_result;
          f3_q    <= i_funct3;
          rd_q    <= i_rd;
          ld_q    <= i_is_load;
          we_q    <= i_is_store;
          wdata_q <= i_is_store ? wdata_n : 32'd0;
          wstrb_q <= i_is_store ? wstrb_n : 4'b0000;
        end else if (i_valid && !mem_op) begin
          o_wb_valid <= 1'b1;
          o_wb_rd    <= i_rd;
          o_wb_data  <= i_rd == 5'd0 ? 32'd0 : i_result;
        end
      end else if (bus.mem_ack) begin
        state      <= IDLE;
        o_wb_valid <= ld_q;
        o_wb_rd    <= rd_q;
        o_wb_data  <= rd_q == 5'd0 ? 32'd0 : fmt;
      end else if (tmo) begin
        // abort: a load still retires with zero so the destination is defined
        state      <= IDLE;
        o_bus_err  <= 1'b1;
        o_wb_valid <= ld_q;
        o_wb_rd    <= rd_q;
        o_wb_data  <= 32'd0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misalign      <= 1'b0;
      o_misalign_addr <= '0;
    end else begin
      o_misalign <= state == IDLE && i_valid && mis;
      if (state == IDLE && i_valid && mis) o_misalign_addr <= i_result;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a 4-cycle bus timeout
module tb_mem_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        i_valid = 0, i_is_load = 0, i_is_store = 0;
  logic [4:0]  i_rd = 0;
  logic [31:0] i_result = 0, i_store_data = 0;
  logic [2:0]  i_funct3 = 0;
  logic        o_ready, o_wb_valid, o_pause, o_bus_err;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic [36:0] o_mem_bypass;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        o_misalign;
  logic [31:0] o_misalign_addr;
`endif
  mem_stage_if bus();
  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .i_valid(i_valid), .o_ready(o_ready), .i_rd(i_rd), .i_result(i_result),
    .i_store_data(i_store_data), .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_mem_bypass(o_mem_bypass), .o_pause(o_pause), .o_bus_err(o_bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
`endif
  );
  int errors = 0, checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_e;
  always @(negedge clk) begin
    if (rst_n && o_wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", o_wb_rd, o_wb_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({o_wb_rd, o_wb_data} !== exp_e) begin
          errors++;
          $display("FAIL wb_value: got %h required %h", {o_wb_rd, o_wb_data}, exp_e);
        end
        checks++;
        if (o_mem_bypass !== exp_e) begin
          errors++;
          $display("FAIL bypass: got %h required %h", o_mem_bypass, exp_e);
        end
      end
    end else if (rst_n) begin
      checks++;
      if (o_mem_bypass !== 37'd0) begin
        errors++;
        $display("FAIL bypass_idle: got %h required 0", o_mem_bypass);
      end
    end
  end
  task automatic issue(input logic [4:0] rd, input logic [31:0] res, sd, input logic ld, st, input logic [2:0] f3);
    i_valid = 1; i_rd = rd; i_result = res; i_store_data = sd; i_is_load = ld; i_is_store = st; i_funct3 = f3;
    @(posedge clk); #1;
    i_valid = 0; i_is_load = 0; i_is_store = 0;
  endtask
  task automatic bus_run(input int n, input bit ack, input logic [31:0] rdata, output int pc);
    pc = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (o_pause) pc++;
      if (k == n && ack) begin bus.mem_ack = 1; bus.mem_rdata = rdata; end
      @(posedge clk); #1;
      bus.mem_ack = 0; bus.mem_rdata = 0;
    end
  endtask
  task automatic drain(input string name);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d outstanding writebacks required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if ({o_wb_valid, o_pause, o_bus_err, bus.mem_req, bus.mem_we, bus.mem_wstrb, o_mem_bypass, bus.mem_addr} !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got wbv=%b pause=%b err=%b req=%b ready=%b required zeros with ready=1", o_wb_valid, o_pause, o_bus_err, bus.mem_req, o_ready);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_alu;
    exp_q.push_back({5'd5, 32'h1234});
    issue(5'd5, 32'h1234, 0, 0, 0, 3'b000);
    checks++;
    if (o_pause !== 1'b0 || o_wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency: got pause=%b wbv=%b required pause=0 wbv=1", o_pause, o_wb_valid);
    end
    drain("alu");
  endtask
  task automatic test_back_to_back;
    exp_q.push_back({5'd1, 32'hA}); exp_q.push_back({5'd2, 32'hB}); exp_q.push_back({5'd3, 32'hC});
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_rd = 5'(k + 1); i_result = 32'(k + 10); i_is_load = 0; i_is_store = 0;
      @(posedge clk); #1;
      checks++;
      if (o_pause !== 1'b0 || o_wb_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got pause=%b wbv=%b required pause=0 wbv=1", k, o_pause, o_wb_valid);
      end
    end
    i_valid = 0;
    drain("b2b");
  endtask
  task automatic test_loads;
    logic [4:0]  rd[6] = '{5'd7, 5'd8, 5'd12, 5'd13, 5'd4, 5'd6};
    logic [31:0] ad[6] = '{32'h103, 32'h103, 32'h12, 32'h12, 32'h111, 32'h118};
    logic [2:0]  f3[6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] rv[6] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000, 32'h8001_0000, 32'h0000_9F00, 32'hCAFE_F00D};
    logic [31:0] ex[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF9F, 32'hCAFE_F00D};
    int pc;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({rd[k], ex[k]});
      issue(rd[k], ad[k], 0, 1, 0, f3[k]);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'b0000 || bus.mem_addr !== {ad[k][31:2], 2'b00} || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_req_%0d: got req=%b we=%b strb=%b addr=%h ready=%b required 1 0 0000 %h 0", k, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, o_ready, {ad[k][31:2], 2'b00});
      end
      bus_run(k < 2 ? 3 : 1 + k % 2, 1, rv[k], pc);
      checks++;
      if (pc !== (k < 2 ? 3 : 1 + k % 2) || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL load_pause_%0d: got pause cycles=%0d req=%b required %0d 0", k, pc, bus.mem_req, k < 2 ? 3 : 1 + k % 2);
      end
      drain("load");
    end
  endtask
  task automatic test_stores;
    logic [31:0] ad[3] = '{32'h202, 32'h301, 32'h404};
    logic [31:0] sd[3] = '{32'h0000_ABCD, 32'h1234_565A, 32'h8765_4321};
    logic [2:0]  f3[3] = '{3'b001, 3'b000, 3'b010};
    logic [3:0]  st[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd[3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h8765_4321};
    int pc;
    for (int k = 0; k < 3; k++) begin
      issue(5'd3, ad[k], sd[k], 0, 1, f3[k]);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wstrb !== st[k] || bus.mem_wdata !== wd[k] || bus.mem_addr !== {ad[k][31:2], 2'b00}) begin
        errors++;
        $display("FAIL store_%0d: got we=%b strb=%b wdata=%h addr=%h required 1 %b %h %h", k, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr, st[k], wd[k], {ad[k][31:2], 2'b00});
      end
      bus_run(1 + k, 1, 32'hFFFF_FFFF, pc);
      checks++;
      if (pc !== 1 + k || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL store_done_%0d: got pause cycles=%0d req=%b required %0d 0", k, pc, bus.mem_req, 1 + k);
      end
      drain("store");
    end
  endtask
  task automatic test_timeout;
    int pc;
    exp_q.push_back({5'd9, 32'd0});
    issue(5'd9, 32'h400, 0, 1, 0, 3'b010);
    bus_run(4, 0, 0, pc);
    checks++;
    if (pc !== 4 || bus.mem_req !== 1'b0 || o_bus_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got pause cycles=%0d req=%b err=%b required 4 0 1", pc, bus.mem_req, o_bus_err);
    end
    drain("timeout");
    checks++;
    if (o_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b required 0", o_bus_err);
    end
    exp_q.push_back({5'd10, 32'h1122_3344});
    issue(5'd10, 32'h404, 0, 1, 0, 3'b010);
    bus_run(4, 1, 32'h1122_3344, pc);
    checks++;
    if (pc !== 4 || o_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_limit: got pause cycles=%0d err=%b required 4 0", pc, o_bus_err);
    end
    drain("ack_at_limit");
  endtask
  task automatic test_reset_mid_bus;
    int pc;
    issue(5'd11, 32'h500, 0, 1, 0, 3'b010);
    bus_run(2, 0, 0, pc);
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || o_pause !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_bus: got req=%b pause=%b ready=%b required 0 0 1", bus.mem_req, o_pause, o_ready);
    end
    @(posedge clk); #2 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_wb_valid !== 1'b0 || o_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_%0d: got wbv=%b ready=%b req=%b required 0 1 0", k, o_wb_valid, o_ready, bus.mem_req);
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_rd_zero;
    int pc;
    exp_q.push_back({5'd0, 32'd0});
    issue(5'd0, 32'h600, 0, 1, 0, 3'b010);
    bus_run(1, 1, 32'h55, pc);
    checks++;
    if (o_wb_valid !== 1'b1 || o_wb_data !== 32'd0) begin
      errors++;
      $display("FAIL rd_zero: got wbv=%b data=%h required 1 0", o_wb_valid, o_wb_data);
    end
    drain("rd_zero");
  endtask
`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign;
    issue(5'd14, 32'h101, 0, 1, 0, 3'b010);
    checks++;
    if (o_misalign !== 1'b1 || o_misalign_addr !== 32'h101 || bus.mem_req !== 1'b0 || o_wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign: got mis=%b addr=%h req=%b wbv=%b required 1 101 0 0", o_misalign, o_misalign_addr, bus.mem_req, o_wb_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_misalign !== 1'b0 || o_misalign_addr !== 32'h101) begin
      errors++;
      $display("FAIL misalign_hold: got mis=%b addr=%h required 0 101", o_misalign, o_misalign_addr);
    end
  endtask
`endif
  initial begin
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    test_reset;
    test_alu;
    test_back_to_back;
    test_loads;
    test_stores;
    test_timeout;
    test_reset_mid_bus;
    test_rd_zero;
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign;
`endif
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outstanding required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
